// File: rtl/usbf_csr_arb.sv
// ---------------------------------------------------------------------------
// usbf_csr_arb
// Shares the single CSR register port between the bus interface unit (BIU)
// and the device core's internal register master, in the PHY clock domain.
// Each request becomes exactly one single-cycle CSR strobe followed by a
// one-cycle done pulse to the requester. When both sides are waiting, the
// grant alternates between them (round-robin on the last grant).
//
// Ports
//   phy_clk_i, hrstn_i          clock, synchronous active-low reset
//   b_wt_en_i, b_rd_en_i        BIU enables (already synchronised, level)
//   b_addr_i, b_wdata_i         BIU address / write data, latched on the edge
//   b_rdata_o, b_done_o         BIU read data, completion pulse
//   b_ovf_o                     sticky: BIU edge dropped while one was pending
//   c_req_i, c_we_i             core request (held until done), 1 = write
//   c_addr_i, c_wdata_i         core address / write data
//   c_gnt_o, c_rdata_o, c_done_o core grant, read data, completion pulse
//   csr_wr_o, csr_rd_o          CSR write / read strobes
//   csr_addr_o, csr_wdata_o     CSR address / write data
//   csr_rdata_i                 CSR read data, valid in the read strobe cycle
// ---------------------------------------------------------------------------
module usbf_csr_arb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          phy_clk_i,
   input  logic          hrstn_i,
   input  logic          b_wt_en_i,
   input  logic          b_rd_en_i,
   input  logic [AW-1:0] b_addr_i,
   input  logic [DW-1:0] b_wdata_i,
   output logic [DW-1:0] b_rdata_o,
   output logic          b_done_o,
   output logic          b_ovf_o,
   input  logic          c_req_i,
   input  logic          c_we_i,
   input  logic [AW-1:0] c_addr_i,
   input  logic [DW-1:0] c_wdata_i,
   output logic          c_gnt_o,
   output logic [DW-1:0] c_rdata_o,
   output logic          c_done_o,
   output logic          csr_wr_o,
   output logic          csr_rd_o,
   output logic [AW-1:0] csr_addr_o,
   output logic [DW-1:0] csr_wdata_o,
   input  logic [DW-1:0] csr_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   // Grant select / last-grant encoding
   localparam logic SEL_BIU  = 1'b0;
   localparam logic SEL_CORE = 1'b1;

   state_t        r_state;
   logic          r_gsel;
   logic          r_lastGnt;
   logic          r_bPend;
   logic          r_bWe;
   logic          r_bWtPrev;
   logic          r_bRdPrev;
   logic          r_bOvf;
   logic [AW-1:0] r_bAddr;
   logic [DW-1:0] r_bWdata;
   logic [AW-1:0] r_addrHold;
   logic [DW-1:0] r_wdataHold;
   logic [DW-1:0] r_bRdata;
   logic [DW-1:0] r_cRdata;

   logic          w_bWtRise;
   logic          w_bRdRise;
   logic          w_bEdge;
   logic          w_winner;
   logic          w_inAccess;
   logic          w_accWe;
   logic [AW-1:0] w_accAddr;
   logic [DW-1:0] w_accWdata;

   // BIU requests are the rising edges of the synchronised enable levels.
   assign w_bWtRise = b_wt_en_i & ~r_bWtPrev;
   assign w_bRdRise = b_rd_en_i & ~r_bRdPrev;
   assign w_bEdge   = w_bWtRise | w_bRdRise;

   // On a tie the side that was not granted last wins; otherwise whoever asks.
   assign w_winner = (r_bPend && c_req_i) ? ~r_lastGnt :
                     (c_req_i ? SEL_CORE : SEL_BIU);

   // The core's address, data and type are taken live in the access cycle;
   // the BIU's come from the values latched at its enable edge.
   assign w_inAccess = (r_state == ACCESS);
   assign w_accWe    = (r_gsel == SEL_CORE) ? c_we_i    : r_bWe;
   assign w_accAddr  = (r_gsel == SEL_CORE) ? c_addr_i  : r_bAddr;
   assign w_accWdata = (r_gsel == SEL_CORE) ? c_wdata_i : r_bWdata;

   // Outside the access cycle the CSR bus shows the last driven values.
   assign csr_wr_o    = w_inAccess &  w_accWe;
   assign csr_rd_o    = w_inAccess & ~w_accWe;
   assign csr_addr_o  = w_inAccess ? w_accAddr  : r_addrHold;
   assign csr_wdata_o = w_inAccess ? w_accWdata : r_wdataHold;

   assign c_gnt_o  = w_inAccess & (r_gsel == SEL_CORE);
   assign b_done_o = (r_state == DONE) & (r_gsel == SEL_BIU);
   assign c_done_o = (r_state == DONE) & (r_gsel == SEL_CORE);
   assign b_ovf_o  = r_bOvf;
   assign b_rdata_o = r_bRdata;
   assign c_rdata_o = r_cRdata;

   // BIU front end plus the IDLE -> ACCESS -> DONE sequencer. A BIU edge that
   // arrives while one is still pending is dropped and flagged as overflow.
   // The pending flag is released as the BIU access leaves ACCESS, so a new
   // edge during its DONE cycle is accepted.
   always_ff @(posedge phy_clk_i) begin
      if (!hrstn_i) begin
         r_state     <= IDLE;
         r_gsel      <= SEL_BIU;
         r_lastGnt   <= SEL_CORE;
         r_bPend     <= 1'b0;
         r_bWe       <= 1'b0;
         r_bWtPrev   <= 1'b0;
         r_bRdPrev   <= 1'b0;
         r_bOvf      <= 1'b0;
         r_bAddr     <= '0;
         r_bWdata    <= '0;
         r_addrHold  <= '0;
         r_wdataHold <= '0;
         r_bRdata    <= '0;
         r_cRdata    <= '0;
      end else begin
         r_bWtPrev <= b_wt_en_i;
         r_bRdPrev <= b_rd_en_i;

         if (w_bEdge) begin
            if (r_bPend) begin
               r_bOvf <= 1'b1;
            end else begin
               r_bPend  <= 1'b1;
               r_bWe    <= w_bWtRise;
               r_bAddr  <= b_addr_i;
               r_bWdata <= b_wdata_i;
            end
         end

         case (r_state)
            IDLE: begin
               if (r_bPend || c_req_i) begin
                  r_gsel    <= w_winner;
                  r_lastGnt <= w_winner;
                  r_state   <= ACCESS;
               end
            end
            ACCESS: begin
               r_addrHold  <= w_accAddr;
               r_wdataHold <= w_accWdata;
               if (!w_accWe) begin
                  if (r_gsel == SEL_CORE) r_cRdata <= csr_rdata_i;
                  else                    r_bRdata <= csr_rdata_i;
               end
               if (r_gsel == SEL_BIU) r_bPend <= 1'b0;
               r_state <= DONE;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usbf_csr_arb.sv
// ---------------------------------------------------------------------------
// tb_usbf_csr_arb
// Directed bench for usbf_csr_arb. Every CSR access the stimulus provokes is
// pushed to a scoreboard queue in the order it should appear; a monitor pops
// and compares each strobe as the arbiter issues it. Cycle-exact checks on
// done, grant, read-data and overflow outputs are made inline.
// ---------------------------------------------------------------------------
module tb_usbf_csr_arb;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } csrAccess_t;

   logic        clk = 1'b0;
   logic        hrstn;
   logic        bWtEn, bRdEn;
   logic [31:0] bAddr, bWdata, bRdata;
   logic        bDone, bOvf;
   logic        cReq, cWe;
   logic [31:0] cAddr, cWdata, cRdata;
   logic        cGnt, cDone;
   logic        csrWr, csrRd;
   logic [31:0] csrAddr, csrWdata, csrRdata;

   int          checkCount = 0;
   int          passCount  = 0;
   int          failCount  = 0;
   int          strobeCount = 0;
   int          base;
   csrAccess_t  sbQ[$];

   usbf_csr_arb #(.AW(32), .DW(32)) dut (
      .phy_clk_i  (clk),
      .hrstn_i    (hrstn),
      .b_wt_en_i  (bWtEn),
      .b_rd_en_i  (bRdEn),
      .b_addr_i   (bAddr),
      .b_wdata_i  (bWdata),
      .b_rdata_o  (bRdata),
      .b_done_o   (bDone),
      .b_ovf_o    (bOvf),
      .c_req_i    (cReq),
      .c_we_i     (cWe),
      .c_addr_i   (cAddr),
      .c_wdata_i  (cWdata),
      .c_gnt_o    (cGnt),
      .c_rdata_o  (cRdata),
      .c_done_o   (cDone),
      .csr_wr_o   (csrWr),
      .csr_rd_o   (csrRd),
      .csr_addr_o (csrAddr),
      .csr_wdata_o(csrWdata),
      .csr_rdata_i(csrRdata)
   );

   // 10-unit clock; the design acts on posedge, the bench on negedge.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected on a miss.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checkCount = checkCount + 1;
      assert (obs === exp) passCount = passCount + 1;
      else begin
         failCount = failCount + 1;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to the n-th following negedge, where outputs are sampled and
   // new inputs are driven.
   task automatic applyStimulus(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expectAccess(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata);
      csrAccess_t a;
      a.wr = wr; a.addr = addr; a.wdata = wdata;
      sbQ.push_back(a);
   endtask

   // Scoreboard monitor: each CSR strobe must match the oldest expectation.
   always @(negedge clk) begin
      csrAccess_t a;
      if (csrWr || csrRd) begin
         strobeCount = strobeCount + 1;
         checkOutput("sb_expected", 32'(sbQ.size() != 0), 32'd1);
         if (sbQ.size() != 0) begin
            a = sbQ.pop_front();
            checkOutput("sb_wr", 32'(csrWr), 32'(a.wr));
            checkOutput("sb_rd", 32'(csrRd), 32'(!a.wr));
            checkOutput("sb_addr", csrAddr, a.addr);
            if (a.wr) checkOutput("sb_wdata", csrWdata, a.wdata);
         end
      end
   end

   initial begin
      hrstn = 1'b0; bWtEn = 1'b0; bRdEn = 1'b0; bAddr = '0; bWdata = '0;
      cReq = 1'b0; cWe = 1'b0; cAddr = '0; cWdata = '0; csrRdata = '0;
      applyStimulus(3);

      // Reset state
      checkOutput("rst_csr_wr", 32'(csrWr), 32'd0);
      checkOutput("rst_csr_rd", 32'(csrRd), 32'd0);
      checkOutput("rst_gnt_done", {29'd0, cGnt, bDone, cDone}, 32'd0);
      checkOutput("rst_ovf", 32'(bOvf), 32'd0);
      checkOutput("rst_addr", csrAddr, 32'd0);
      checkOutput("rst_wdata", csrWdata, 32'd0);
      checkOutput("rst_b_rdata", bRdata, 32'd0);
      checkOutput("rst_c_rdata", cRdata, 32'd0);
      hrstn = 1'b1;
      applyStimulus(1);

      // BIU write, enable held four cycles: one strobe two cycles after edge
      base = strobeCount;
      bWtEn = 1'b1; bAddr = 32'h10; bWdata = 32'hA5A5_0001;
      expectAccess(1'b1, 32'h10, 32'hA5A5_0001);
      applyStimulus(1);
      checkOutput("t1_no_early_wr", 32'(csrWr), 32'd0);
      applyStimulus(1);
      checkOutput("t1_wr", 32'(csrWr), 32'd1);
      checkOutput("t1_no_early_done", 32'(bDone), 32'd0);
      applyStimulus(1);
      checkOutput("t1_done", 32'(bDone), 32'd1);
      checkOutput("t1_wr_off", 32'(csrWr), 32'd0);
      checkOutput("t1_addr_hold", csrAddr, 32'h10);
      applyStimulus(1);
      checkOutput("t1_done_pulse", 32'(bDone), 32'd0);
      bWtEn = 1'b0;
      applyStimulus(2);
      checkOutput("t1_one_strobe", 32'(strobeCount - base), 32'd1);

      // Core read
      cReq = 1'b1; cWe = 1'b0; cAddr = 32'h20; csrRdata = 32'h1234_5678;
      expectAccess(1'b0, 32'h20, 32'h0);
      applyStimulus(1);
      checkOutput("t2_rd", 32'(csrRd), 32'd1);
      checkOutput("t2_gnt", 32'(cGnt), 32'd1);
      applyStimulus(1);
      checkOutput("t2_done", 32'(cDone), 32'd1);
      checkOutput("t2_gnt_off", 32'(cGnt), 32'd0);
      checkOutput("t2_c_rdata", cRdata, 32'h1234_5678);
      cReq = 1'b0;
      applyStimulus(1);
      checkOutput("t2_done_pulse", 32'(cDone), 32'd0);
      checkOutput("t2_c_rdata_hold", cRdata, 32'h1234_5678);
      checkOutput("t2_b_rdata_untouched", bRdata, 32'd0);

      // Tie out of reset: BIU first, then core
      hrstn = 1'b0;
      applyStimulus(2);
      checkOutput("t3_rst_c_rdata", cRdata, 32'd0);
      hrstn = 1'b1;
      bRdEn = 1'b1; bAddr = 32'h30; csrRdata = 32'hBEEF_0030;
      expectAccess(1'b0, 32'h30, 32'h0);
      expectAccess(1'b1, 32'h40, 32'hC0DE_0040);
      applyStimulus(1);
      cReq = 1'b1; cWe = 1'b1; cAddr = 32'h40; cWdata = 32'hC0DE_0040;
      applyStimulus(1);
      checkOutput("t3_biu_first_rd", 32'(csrRd), 32'd1);
      checkOutput("t3_biu_first_gnt", 32'(cGnt), 32'd0);
      applyStimulus(1);
      checkOutput("t3_b_done", 32'(bDone), 32'd1);
      checkOutput("t3_b_rdata", bRdata, 32'hBEEF_0030);
      bRdEn = 1'b0;
      applyStimulus(2);
      checkOutput("t3_core_gnt", 32'(cGnt), 32'd1);
      checkOutput("t3_core_wr", 32'(csrWr), 32'd1);
      applyStimulus(1);
      checkOutput("t3_c_done", 32'(cDone), 32'd1);
      cReq = 1'b0;
      applyStimulus(1);

      // Tie after a BIU grant: core first, then BIU
      bWtEn = 1'b1; bAddr = 32'h50; bWdata = 32'h5555_0050;
      expectAccess(1'b1, 32'h50, 32'h5555_0050);
      applyStimulus(1);
      bWtEn = 1'b0;
      applyStimulus(1);
      checkOutput("t4_biu_wr", 32'(csrWr), 32'd1);
      cReq = 1'b1; cWe = 1'b0; cAddr = 32'h60; csrRdata = 32'h6666_0060;
      checkOutput("t4_no_gnt_in_biu", 32'(cGnt), 32'd0);
      applyStimulus(1);
      checkOutput("t4_b_done", 32'(bDone), 32'd1);
      bRdEn = 1'b1; bAddr = 32'h70;
      expectAccess(1'b0, 32'h60, 32'h0);
      expectAccess(1'b0, 32'h70, 32'h0);
      applyStimulus(1);
      checkOutput("t4_idle_gnt", 32'(cGnt), 32'd0);
      applyStimulus(1);
      checkOutput("t4_core_first", 32'(cGnt), 32'd1);
      applyStimulus(1);
      checkOutput("t4_c_done", 32'(cDone), 32'd1);
      checkOutput("t4_c_rdata", cRdata, 32'h6666_0060);
      cReq = 1'b0; csrRdata = 32'h7777_0070;
      applyStimulus(2);
      checkOutput("t4_biu_rd", 32'(csrRd), 32'd1);
      applyStimulus(1);
      checkOutput("t4_b_done2", 32'(bDone), 32'd1);
      checkOutput("t4_b_rdata", bRdata, 32'h7777_0070);
      checkOutput("t4_no_ovf", 32'(bOvf), 32'd0);
      bRdEn = 1'b0;
      applyStimulus(1);

      // Core write, BIU edge during its access, second BIU edge -> overflow
      base = strobeCount;
      cReq = 1'b1; cWe = 1'b1; cAddr = 32'h90; cWdata = 32'h9999_0090;
      expectAccess(1'b1, 32'h90, 32'h9999_0090);
      applyStimulus(1);
      checkOutput("t5_core_wr", 32'(csrWr), 32'd1);
      bWtEn = 1'b1; bAddr = 32'h80; bWdata = 32'h8888_0080;
      expectAccess(1'b1, 32'h80, 32'h8888_0080);
      applyStimulus(1);
      checkOutput("t5_c_done", 32'(cDone), 32'd1);
      checkOutput("t5_wr_keeps_rdata", cRdata, 32'h6666_0060);
      cReq = 1'b0;
      bRdEn = 1'b1; bAddr = 32'hEE; bWdata = 32'hEEEE_EEEE;
      applyStimulus(1);
      checkOutput("t5_ovf", 32'(bOvf), 32'd1);
      checkOutput("t5_rdata_still", cRdata, 32'h6666_0060);
      applyStimulus(1);
      checkOutput("t5_biu_wr", 32'(csrWr), 32'd1);
      bWtEn = 1'b0; bRdEn = 1'b0;
      applyStimulus(1);
      checkOutput("t5_b_done", 32'(bDone), 32'd1);
      applyStimulus(1);
      checkOutput("t5_ovf_sticky", 32'(bOvf), 32'd1);
      checkOutput("t5_two_strobes", 32'(strobeCount - base), 32'd2);

      // Core read after the write updates read data
      cReq = 1'b1; cWe = 1'b0; cAddr = 32'hA0; csrRdata = 32'hAAAA_00A0;
      expectAccess(1'b0, 32'hA0, 32'h0);
      applyStimulus(2);
      checkOutput("t6_c_rdata", cRdata, 32'hAAAA_00A0);
      cReq = 1'b0;
      applyStimulus(1);

      // Reset during a BIU access: no done, pending dropped, outputs cleared
      base = strobeCount;
      bWtEn = 1'b1; bAddr = 32'hB0; bWdata = 32'hBBBB_00B0;
      expectAccess(1'b1, 32'hB0, 32'hBBBB_00B0);
      applyStimulus(1);
      bWtEn = 1'b0;
      applyStimulus(1);
      checkOutput("t7_wr", 32'(csrWr), 32'd1);
      hrstn = 1'b0;
      applyStimulus(1);
      checkOutput("t7_wr_off", 32'(csrWr), 32'd0);
      checkOutput("t7_no_done", {30'd0, bDone, cDone}, 32'd0);
      checkOutput("t7_gnt", 32'(cGnt), 32'd0);
      checkOutput("t7_addr", csrAddr, 32'd0);
      checkOutput("t7_wdata", csrWdata, 32'd0);
      checkOutput("t7_b_rdata", bRdata, 32'd0);
      checkOutput("t7_c_rdata", cRdata, 32'd0);
      checkOutput("t7_ovf", 32'(bOvf), 32'd0);
      hrstn = 1'b1;
      applyStimulus(1);
      checkOutput("t7_no_done_after", 32'(bDone), 32'd0);
      applyStimulus(3);
      checkOutput("t7_no_replay", 32'(strobeCount - base), 32'd1);
      checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/usbf_csr_arb.md
# usbf_csr_arb

CSR access arbiter in the PHY clock domain. It shares the single CSR register port between two requesters: the bus interface unit (synchronised AHB write/read enables) and the device core's internal register master. Each request becomes exactly one single-cycle CSR strobe, with read data captured per requester. Arbitration is round-robin, and each access reports completion with a one-cycle done pulse.

## Interface
- AW, 32, address width
- DW, 32, data width
- phy_clk_i  in  1  PHY clock; all logic on its rising edge
- hrstn_i  in  1  reset, synchronous, active-low
- b_wt_en_i  in  1  BIU write enable, already synchronised to phy_clk_i; level may last several cycles
- b_rd_en_i  in  1  BIU read enable, same form as b_wt_en_i
- b_addr_i  in  AW  BIU address
- b_wdata_i  in  DW  BIU write data
- b_rdata_o  out  DW  last BIU read data
- b_done_o  out  1  BIU access complete, 1-cycle pulse
- b_ovf_o  out  1  sticky: BIU request edge arrived while one was already pending
- c_req_i  in  1  core request; held until c_done_o
- c_we_i  in  1  core request type: 1 = write, 0 = read
- c_addr_i  in  AW  core address
- c_wdata_i  in  DW  core write data
- c_gnt_o  out  1  core request in its CSR access cycle
- c_rdata_o  out  DW  last core read data
- c_done_o  out  1  core access complete, 1-cycle pulse
- csr_wr_o  out  1  CSR write strobe
- csr_rd_o  out  1  CSR read strobe
- csr_addr_o  out  AW  CSR address
- csr_wdata_o  out  DW  CSR write data
- csr_rdata_i  in  DW  CSR read data; combinational, valid in the csr_rd_o cycle

## Operation
- BIU front end:
  - Registers the previous b_wt_en_i and b_rd_en_i.
  - A rising edge on either sets b_pend, latches the type (write wins if both rise together), and latches b_addr_i and b_wdata_i in the same cycle.
  - A rising edge while b_pend=1 is dropped and sets b_ovf_o.
  - b_pend clears on entry to DONE for a BIU grant.
- Core port: a request is c_req_i=1. Address, data and type are sampled in the ACCESS cycle.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if b_pend or c_req_i is set, record the winner in gsel and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: exactly one cycle. Drive csr_addr_o and csr_wdata_o from the winner. Assert csr_wr_o or csr_rd_o per type. On a read, capture csr_rdata_i into b_rdata_o or c_rdata_o. Go to DONE.
  - DONE: one cycle. Assert b_done_o or c_done_o per gsel. No arbitration. Go to IDLE.
- Arbitration:
  - A single requester wins outright.
  - When both request, the winner is the one not granted last (last_gnt).
  - last_gnt resets to core, so the BIU wins the first tie.
- Outside ACCESS: csr_wr_o=csr_rd_o=0. csr_addr_o and csr_wdata_o hold their last values.
- c_gnt_o=1 only in ACCESS with gsel=core.
- Read-data registers hold until the same port's next read. Writes never alter them.

## Timing
- Reset values: state=IDLE, b_pend=0, last_gnt=core, b_ovf_o=0, all strobes, gnt and done outputs 0, rdata/addr/wdata outputs 0.
- BIU latency, edge sampled at cycle t:
  - b_pend=1 at t+1.
  - ACCESS (strobe) at t+2 if idle.
  - b_done_o at t+3.
- Core latency, c_req_i=1 in IDLE at cycle t: ACCESS at t+1, c_done_o at t+2.
- Peak throughput: one access per 3 cycles.
- Core must deassert c_req_i in the cycle after c_done_o, or present its next request then.
- Requests during ACCESS or DONE wait; none are lost except BIU overflow.
- A BIU edge during ACCESS or DONE of a core grant is latched normally.
- hrstn_i low mid-access: state returns to IDLE next edge. Pending request is discarded, no done pulse is issued, rdata registers clear.

## Test plan
- BIU write, addr 0x10, data 0xA5A5_0001, b_wt_en_i high 4 cycles -> exactly one csr_wr_o pulse with those values 2 cycles after the edge; b_done_o 1 cycle later.
- Core read, addr 0x20, with csr_rdata_i=0x1234_5678 -> csr_rd_o in the cycle after the request; c_rdata_o=0x1234_5678 from the DONE cycle on; c_gnt_o high one cycle.
- Simultaneous BIU and core requests out of reset -> BIU served first, then core; repeat the tie -> core first.
- Second BIU edge while b_pend=1 -> b_ovf_o=1 and sticky; only one csr strobe issued.
- Reset asserted during ACCESS -> next cycle all outputs at reset values, no done pulse, b_pend=0.
- Core write followed by a core read -> c_rdata_o unchanged by the write, updated only by the read.
